// File: rtl/raspi_cmd_router.sv
// Command/data router for the RasPi 9-bit word stream: selects IDLE, LINK (echo)
// or FWLOAD (firmware packing into program memory) and drives the CPU reset request.
module raspi_cmd_router #(
    parameter int FIFO_DEPTH    = 4,
    parameter int MEM_ADDR_BITS = 14
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8:0]               in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8:0]               out_data,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic [31:0]              mem_wdata,
    output logic                     cpu_resetn,
    output logic                     fw_wrap
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LINK   = 2'd1,
        ST_FWLOAD = 2'd2,
        ST_IGNORE = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic                       cpu_resetn_q, cpu_resetn_d;
    logic [7:0]                 fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]                fifo_cnt_q, fifo_cnt_d;
    logic                       stage_vld_q, stage_vld_d;
    logic [7:0]                 stage_q, stage_d;
    logic [1:0]                 byte_cnt_q, byte_cnt_d;
    logic [31:0]                wdata_q, wdata_d;
    logic                       mem_valid_q, mem_valid_d;
    logic [MEM_ADDR_BITS-1:0]   addr_q, addr_d;
    logic                       wrap_q, wrap_d;
    logic [PW:0]                occ_s;
    logic                       fifo_full_s, accept_s, push_s, pop_s;

    function automatic logic [7:0] echo_xform(input logic [7:0] d);
        logic [7:0] t;
        t = {d[2:0], 5'b00000} + d;
        return t ^ 8'h07;
    endfunction

    // The staged echo counts toward occupancy so the FIFO always has room for it.
    assign occ_s       = fifo_cnt_q + {{PW{1'b0}}, stage_vld_q};
    assign fifo_full_s = (occ_s == DEPTH_C);
    assign in_ready    = !((state_q == ST_LINK) && fifo_full_s) && !mem_valid_q;
    assign accept_s    = in_valid && in_ready;
    assign push_s      = stage_vld_q;
    assign out_valid   = (fifo_cnt_q != {(PW+1){1'b0}});
    assign pop_s       = out_valid && out_ready;
    assign out_data    = {1'b0, fifo_mem_q[rd_ptr_q]};
    assign mem_valid   = mem_valid_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign cpu_resetn  = cpu_resetn_q;
    assign fw_wrap     = wrap_q;

    // Next-state: command decode, echo staging, firmware packing and write handshake
    always_comb begin
        state_d      = state_q;
        cpu_resetn_d = cpu_resetn_q;
        stage_vld_d  = 1'b0;
        stage_d      = stage_q;
        byte_cnt_d   = byte_cnt_q;
        wdata_d      = wdata_q;
        mem_valid_d  = mem_valid_q;
        addr_d       = addr_q;
        wrap_d       = wrap_q;
        if (accept_s && in_data[8]) begin
            byte_cnt_d = 2'd0;
            case (in_data[7:0])
                8'hff: begin
                    state_d      = ST_IDLE;
                    cpu_resetn_d = 1'b1;
                end
                8'h00: begin
                    state_d      = ST_LINK;
                    cpu_resetn_d = 1'b0;
                end
                8'h01: begin
                    state_d      = ST_FWLOAD;
                    cpu_resetn_d = 1'b0;
                    addr_d       = {MEM_ADDR_BITS{1'b0}};
                    wrap_d       = 1'b0;
                end
                default: begin
                    state_d      = ST_IGNORE;
                    cpu_resetn_d = 1'b0;
                end
            endcase
        end else if (accept_s) begin
            case (state_q)
                ST_LINK: begin
                    stage_vld_d = 1'b1;
                    stage_d     = echo_xform(in_data[7:0]);
                end
                ST_FWLOAD: begin
                    case (byte_cnt_q)
                        2'd0:    wdata_d[7:0]   = in_data[7:0];
                        2'd1:    wdata_d[15:8]  = in_data[7:0];
                        2'd2:    wdata_d[23:16] = in_data[7:0];
                        default: wdata_d[31:24] = in_data[7:0];
                    endcase
                    mem_valid_d = (byte_cnt_q == 2'd3);
                    byte_cnt_d  = byte_cnt_q + 2'd1;
                end
                default: stage_vld_d = 1'b0;
            endcase
        end else if (mem_valid_q && mem_ready) begin
            mem_valid_d = 1'b0;
            addr_d      = addr_q + {{(MEM_ADDR_BITS-1){1'b0}}, 1'b1};
            wrap_d      = wrap_q || (&addr_q);
        end else begin
            mem_valid_d = mem_valid_q;
        end
    end

    // Echo FIFO pointer and occupancy bookkeeping
    always_comb begin
        rd_ptr_d   = pop_s  ? rd_ptr_q + {{(PW-1){1'b0}}, 1'b1} : rd_ptr_q;
        wr_ptr_d   = push_s ? wr_ptr_q + {{(PW-1){1'b0}}, 1'b1} : wr_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + {{PW{1'b0}}, 1'b1};
            2'b01:   fifo_cnt_d = fifo_cnt_q - {{PW{1'b0}}, 1'b1};
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Control and datapath registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cpu_resetn_q <= 1'b0;
            rd_ptr_q     <= {PW{1'b0}};
            wr_ptr_q     <= {PW{1'b0}};
            fifo_cnt_q   <= {(PW+1){1'b0}};
            stage_vld_q  <= 1'b0;
            stage_q      <= 8'h00;
            byte_cnt_q   <= 2'd0;
            wdata_q      <= 32'h0000_0000;
            mem_valid_q  <= 1'b0;
            addr_q       <= {MEM_ADDR_BITS{1'b0}};
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_resetn_q <= cpu_resetn_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            stage_vld_q  <= stage_vld_d;
            stage_q      <= stage_d;
            byte_cnt_q   <= byte_cnt_d;
            wdata_q      <= wdata_d;
            mem_valid_q  <= mem_valid_d;
            addr_q       <= addr_d;
            wrap_q       <= wrap_d;
        end
    end

    // Echo FIFO storage
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= 8'h00;
            end
        end else if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= stage_q;
        end
    end
endmodule
